// File: rtl/risc16_uart_tx_mmio.sv
`timescale 1ns/1ps
// risc16_uart_tx_mmio
// Memory-mapped 8N1 UART transmitter on the risc16b data-memory port.
// Store bytes written to TXDATA are queued in a small FIFO and sent LSB first.
// Read data for STATUS and DIVISOR is returned combinationally in the same cycle.
//
// Ports
//   clk       system clock, all state on rising edge
//   rst       asynchronous active-high reset
//   d_addr    core data byte address
//   d_oe      core read strobe (reads have no side effects)
//   d_we      byte-lane write enables: [0] -> d_dout[15:8], [1] -> d_dout[7:0]
//   d_dout    core store data
//   mmio_sel  address falls inside the 8-byte window at BASE
//   mmio_din  read data, zero unless mmio_sel & d_oe
//   uart_tx   registered serial output, idle high
//
// Register map (byte offsets): +0 TXDATA (W), +2 STATUS (R, OVF is W1C),
// +4 DIVISOR (R/W, bit period = DIVISOR+1 clocks), +6 reserved.
module risc16_uart_tx_mmio #(
  parameter logic [15:0] BASE       = 16'hFF00,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd867
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_addr,
  input  logic        d_oe,
  input  logic [1:0]  d_we,
  input  logic [15:0] d_dout,
  output logic        mmio_sel,
  output logic [15:0] mmio_din,
  output logic        uart_tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Bus decode
  logic [1:0] word_off;
  logic       wr_en;
  logic       push_req;
  logic       ovf_clr;
  logic [7:0] push_byte;
  logic       unused_addr_lsb;

  assign mmio_sel        = (d_addr[15:3] == BASE[15:3]);
  assign word_off        = d_addr[2:1];
  assign wr_en           = mmio_sel && (d_we != 2'b00);
  assign push_req        = wr_en && (word_off == 2'd0);
  // Bit 3 of STATUS lives in the odd (low) byte, which is lane d_we[1].
  assign ovf_clr         = wr_en && (word_off == 2'd1) && d_we[1] && d_dout[3];
  // Only an even-byte store carries its data in the upper half of d_dout.
  assign push_byte       = (d_we == 2'b01) ? d_dout[15:8] : d_dout[7:0];
  // Byte selection within a word is done by the lane enables, not the address LSB.
  assign unused_addr_lsb = d_addr[0];

  // FIFO and control registers
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic [15:0]   divisor;
  logic          fifo_full, fifo_empty, push_ok, pop;

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign push_ok    = push_req && (!fifo_full || pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      divisor <= DIV_RESET;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_req && fifo_full && !pop) ovf <= 1'b1;
      else if (ovf_clr)                  ovf <= 1'b0;
      if (wr_en && (word_off == 2'd2)) begin
        if (d_we[0]) divisor[15:8] <= d_dout[15:8];
        if (d_we[1]) divisor[7:0]  <= d_dout[7:0];
      end
    end
  end

  // NOTE: the FIFO storage has no reset; count and the pointers decide which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_byte;
  end

  // Transmit FSM
  state_t      state, state_nx;
  logic [15:0] baud_cnt, baud_nx;
  logic [15:0] div_lat, div_lat_nx;
  logic [2:0]  bit_cnt, bit_nx;
  logic [7:0]  shift, shift_nx;
  logic        tx_nx;
  logic        baud_done;

  assign baud_done = (baud_cnt == div_lat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      div_lat  <= DIV_RESET;
      bit_cnt  <= '0;
      shift    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      div_lat  <= div_lat_nx;
      bit_cnt  <= bit_nx;
      shift    <= shift_nx;
      uart_tx  <= tx_nx;
    end
  end

  // NOTE: every output of this block is given a default first so that no path
  // leaves a variable unassigned and infers a latch.
  always_comb begin
    state_nx   = state;
    baud_nx    = baud_cnt;
    div_lat_nx = div_lat;
    bit_nx     = bit_cnt;
    shift_nx   = shift;
    tx_nx      = uart_tx;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        tx_nx = 1'b1;
        pop   = !fifo_empty;
      end
      START: begin
        if (baud_done) begin
          baud_nx  = '0;
          bit_nx   = '0;
          tx_nx    = shift[0];
          state_nx = DATA;
        end else begin
          baud_nx = baud_cnt + 16'd1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_nx = '0;
          if (bit_cnt == 3'd7) begin
            tx_nx    = 1'b1;
            state_nx = STOP;
          end else begin
            bit_nx   = bit_cnt + 3'd1;
            shift_nx = {1'b0, shift[7:1]};
            tx_nx    = shift[1];
          end
        end else begin
          baud_nx = baud_cnt + 16'd1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_nx  = '0;
          state_nx = IDLE;
          pop      = !fifo_empty;
        end else begin
          baud_nx = baud_cnt + 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Starting a frame (from IDLE, or straight out of STOP with no gap).
    if (pop) begin
      shift_nx   = fifo_mem[rd_ptr];
      div_lat_nx = divisor;
      baud_nx    = '0;
      tx_nx      = 1'b0;
      state_nx   = START;
    end
  end

  // Read mux
  always_comb begin
    mmio_din = 16'h0000;
    if (mmio_sel && d_oe) begin
      case (word_off)
        2'd1:    mmio_din = {8'h00, 4'(count), ovf, (state != IDLE), fifo_empty, fifo_full};
        2'd2:    mmio_din = divisor;
        default: mmio_din = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_risc16_uart_tx_mmio.sv
`timescale 1ns/1ps
// Testbench for risc16_uart_tx_mmio. Stimulus pushes the frame it expects
// (byte plus the bit period it should use) onto a scoreboard; an independent
// monitor watches uart_tx, pops the scoreboard on every start bit and compares
// the whole waveform, cycle by cycle, against the ideal 8N1 frame.
module tb_risc16_uart_tx_mmio;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] d_addr = 16'h0000;
  logic        d_oe = 1'b0;
  logic [1:0]  d_we = 2'b00;
  logic [15:0] d_dout = 16'h0000;
  logic        mmio_sel;
  logic [15:0] mmio_din;
  logic        uart_tx;

  risc16_uart_tx_mmio dut (
    .clk      (clk),
    .rst      (rst),
    .d_addr   (d_addr),
    .d_oe     (d_oe),
    .d_we     (d_we),
    .d_dout   (d_dout),
    .mmio_sel (mmio_sel),
    .mmio_din (mmio_din),
    .uart_tx  (uart_tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         div;
  } frame_t;

  frame_t sb[$];
  int     starts[$];
  int     cyc = 0;
  bit     mon_en = 1'b0;
  int     vectors = 0;
  int     miscompares = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input int dv);
    frame_t f;
    f.data = d;
    f.div  = dv;
    sb.push_back(f);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] data, input logic [1:0] we);
    @(negedge clk);
    d_addr = a;
    d_dout = data;
    d_we   = we;
    @(posedge clk);
    #1;
    d_we = 2'b00;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] v);
    @(negedge clk);
    d_addr = a;
    d_oe   = 1'b1;
    #1;
    v    = mmio_din;
    d_oe = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    logic [15:0] st;
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      rd(16'hFF02, st);
      if (!st[2] && st[1]) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_idle_reached", 32'(ok), 32'd1);
  endtask

  // Monitor: one check per observed frame (bit values at each bit start plus
  // count of cycles where the line deviated from the ideal frame).
  initial begin : monitor
    frame_t     e;
    logic [9:0] exp_bits, act_bits;
    int         errs, per;
    forever begin
      @(negedge clk);
      if (mon_en && uart_tx === 1'b0) begin
        starts.push_back(cyc);
        if (sb.size() == 0) begin
          check("start_bit_with_empty_scoreboard", 32'(sb.size()), 32'd1);
          for (int k = 0; k < 100000 && uart_tx !== 1'b1; k++) @(negedge clk);
        end else begin
          e        = sb.pop_front();
          exp_bits = {1'b1, e.data, 1'b0};
          per      = e.div + 1;
          errs     = 0;
          act_bits = '0;
          for (int i = 0; i < 10 * per; i++) begin
            if (i > 0) @(negedge clk);
            if (i % per == 0) act_bits[i / per] = uart_tx;
            if (uart_tx !== exp_bits[i / per]) errs++;
          end
          check($sformatf("frame_%02h_div%0d", e.data, e.div),
                {22'(errs), act_bits}, {22'd0, exp_bits});
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] v;
    logic [7:0]  b;
    int          n0, dv, n, form;

    // 1: async reset mid-frame, reset register values
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wr(16'hFF00, 16'h005A, 2'b11);
    wr(16'hFF00, 16'h0077, 2'b11);
    repeat (20) @(posedge clk);
    #1 check("t1_mid_frame_tx_low", 32'(uart_tx), 32'd0);
    #2 rst = 1'b1;
    #1 check("t1_async_reset_tx_high", 32'(uart_tx), 32'd1);
    rd(16'hFF02, v);
    check("t1_status_after_reset", 32'(v), 32'h0002);
    rd(16'hFF04, v);
    check("t1_divisor_after_reset", 32'(v), 32'd867);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // 2: DIVISOR=3, word write 0x0055, latency and BUSY timing
    wr(16'hFF04, 16'h0003, 2'b11);
    expect_frame(8'h55, 3);
    wr(16'hFF00, 16'h0055, 2'b11);
    check("t2_tx_high_at_push_edge", 32'(uart_tx), 32'd1);
    @(posedge clk);
    #1 check("t2_tx_low_one_edge_later", 32'(uart_tx), 32'd0);
    repeat (39) @(posedge clk);
    rd(16'hFF02, v);
    check("t2_busy_at_n40", 32'(v[2]), 32'd1);
    @(posedge clk);
    rd(16'hFF02, v);
    check("t2_busy_clear_at_n41", 32'(v[2]), 32'd0);

    // 3: byte-lane stores, back-to-back frames
    wait_idle(2000);
    expect_frame(8'hA5, 3);
    wr(16'hFF00, {8'hA5, 8'($urandom)}, 2'b01);
    expect_frame(8'h3C, 3);
    wr(16'hFF01, {8'($urandom), 8'h3C}, 2'b10);
    wait_idle(2000);
    n0 = starts.size();
    check("t3_back_to_back_start_spacing", 32'(starts[n0-1] - starts[n0-2]), 32'd40);

    // 4: overflow with DIVISOR=0, W1C of OVF
    wr(16'hFF04, 16'h0000, 2'b11);
    wait_idle(200);
    for (int i = 0; i < 6; i++) begin
      b = 8'(i * 17 + 3);
      if (i < 5) expect_frame(b, 0);
      wr(16'hFF00, {8'h00, b}, 2'b11);
    end
    rd(16'hFF02, v);
    check("t4_ovf_set", 32'(v[3]), 32'd1);
    check("t4_full_count4", 32'({v[7:4], v[0]}), 32'({4'd4, 1'b1}));
    wait_idle(500);
    rd(16'hFF02, v);
    check("t4_status_idle_ovf_sticky", 32'(v), 32'h000A);
    wr(16'hFF02, 16'h0007, 2'b11);
    rd(16'hFF02, v);
    check("t4_ovf_kept_without_bit3", 32'(v), 32'h000A);
    wr(16'hFF02, 16'h0008, 2'b11);
    rd(16'hFF02, v);
    check("t4_ovf_cleared_w1c", 32'(v), 32'h0002);

    // 5: DIVISOR change mid-frame applies from the next frame
    wr(16'hFF04, 16'h0003, 2'b11);
    expect_frame(8'hC3, 3);
    wr(16'hFF00, 16'h00C3, 2'b11);
    repeat (5) @(posedge clk);
    wr(16'hFF04, 16'h1234, 2'b11);
    rd(16'hFF04, v);
    check("t5_divisor_readback", 32'(v), 32'h1234);
    expect_frame(8'h96, 16'h1234);
    wr(16'hFF00, 16'h0096, 2'b11);
    wait_idle(50000);

    // 6: read strobe gating, decode window, reserved and lane writes
    @(negedge clk);
    d_addr = 16'hFF02;
    d_oe   = 1'b0;
    #1 check("t6_din_zero_without_oe", 32'(mmio_din), 32'h0000);
    check("t6_sel_in_window", 32'(mmio_sel), 32'd1);
    d_addr = 16'hFF08;
    #1 check("t6_sel_outside_window", 32'(mmio_sel), 32'd0);
    wr(16'hFF08, 16'h00FF, 2'b11);
    wr(16'hFF0C, 16'hFFFF, 2'b11);
    wr(16'hFF06, 16'hFFFF, 2'b11);
    rd(16'hFF08, v);
    check("t6_din_outside_window", 32'(v), 32'h0000);
    rd(16'hFF06, v);
    check("t6_reserved_reads_zero", 32'(v), 32'h0000);
    rd(16'hFF00, v);
    check("t6_txdata_reads_zero", 32'(v), 32'h0000);
    rd(16'hFF02, v);
    check("t6_status_unchanged", 32'(v), 32'h0002);
    rd(16'hFF04, v);
    check("t6_divisor_unchanged", 32'(v), 32'h1234);
    wr(16'hFF04, 16'hAB00, 2'b01);
    rd(16'hFF04, v);
    check("t6_divisor_even_lane", 32'(v), 32'hAB34);
    wr(16'hFF05, 16'h00CD, 2'b10);
    rd(16'hFF04, v);
    check("t6_divisor_odd_lane", 32'(v), 32'hABCD);

    // Randomized batches: small divisors, mixed store forms, random gaps
    for (int t = 0; t < 8; t++) begin
      dv = $urandom_range(0, 4);
      n  = $urandom_range(1, 4);
      wr(16'hFF04, 16'(dv), 2'b11);
      rd(16'hFF04, v);
      check("rnd_divisor_readback", 32'(v), 32'(dv));
      for (int k = 0; k < n; k++) begin
        b    = 8'($urandom);
        form = $urandom_range(0, 2);
        expect_frame(b, dv);
        case (form)
          0:       wr(16'hFF00, {8'($urandom), b}, 2'b11);
          1:       wr(16'hFF00, {b, 8'($urandom)}, 2'b01);
          default: wr(16'hFF01, {8'($urandom), b}, 2'b10);
        endcase
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      wait_idle(1000);
    end

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
